// File: rtl/lc3_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_io_pkg
//  Description : Shared constants for the LC3 console transmit path: UART
//                framing widths, default baud divisor and tx state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package lc3_io_pkg;

    // 8N1 framing: one start bit, eight data bits, one stop bit
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    // 50 MHz system clock divided down to 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // Transmitter state encoding
    localparam int         TX_STATE_W = 2;
    localparam logic [1:0] TX_IDLE    = 2'd0;
    localparam logic [1:0] TX_START   = 2'd1;
    localparam logic [1:0] TX_DATA    = 2'd2;
    localparam logic [1:0] TX_STOP    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/lc3_char_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_char_fifo
//  Description : Synchronous byte FIFO with combinational head read. A push
//                into a full FIFO is accepted only when a pop happens in the
//                same cycle; the caller decides what a dropped push means.
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3_char_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Guard against underflow, and let a full FIFO accept a push only when
    // the head slot is being freed in the same cycle.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign full  = (r_count == c_DEPTH);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // Storage write; when full with a pop the write lands on the head slot,
    // which is safe because the old head is read before this edge.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/lc3_console_tx.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_console_tx
//  Description : Console display sink for the LC3. Bytes written to the
//                display data register are queued in a small FIFO and sent
//                out as 8N1 UART frames on TXD, with busy/fill/overflow
//                status for debug.
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3_console_tx
    import lc3_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   DDR,
    input  logic                          WR_DDR,
    output logic                          TXD,
    output logic                          TX_BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_CNT,
    output logic                          OVF
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(UART_DATA_BITS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] c_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  c_BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

    logic [TX_STATE_W-1:0] r_state;
    logic [TX_STATE_W-1:0] w_state_next;
    logic [BAUD_W-1:0]     r_baud;
    logic [BIT_W-1:0]      r_bit_idx;
    logic [BIT_W-1:0]      w_bit_next;
    logic [7:0]            r_data;
    logic                  r_txd;
    logic                  w_txd_next;
    logic                  r_ovf;

    logic                  w_baud_done;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [7:0]            w_head;
    logic [CNT_W-1:0]      w_count;
    logic                  w_unused_ddr_hi;

    // Only the low byte carries a character
    assign w_unused_ddr_hi = ^DDR[15:8];

    assign w_baud_done = (r_baud == c_BAUD_LAST);

    // A character leaves the FIFO only when the line is idle
    assign w_pop = (r_state == TX_IDLE) && !w_fifo_empty;

    lc3_char_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (WR_DDR),
        .pop   (w_pop),
        .din   (DDR[7:0]),
        .dout  (w_head),
        .count (w_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // State, bit timing and frame data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= TX_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_bit_idx <= w_bit_next;
            r_txd     <= w_txd_next;
            // Every state/bit change happens on a baud wrap, so clearing on
            // wrap (and while idle) restarts the count at each boundary.
            if (r_state == TX_IDLE || w_baud_done) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + BAUD_W'(1);
            end
            if (w_pop) begin
                r_data <= w_head;
            end
        end
    end

    // Sticky overflow: a write arrived with the FIFO full and no slot freed
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (WR_DDR && w_fifo_full && !w_pop) begin
            r_ovf <= 1'b1;
        end
    end

    // Next-state and next-bit-index decode
    always_comb begin
        w_state_next = r_state;
        w_bit_next   = '0;
        case (r_state)
            TX_IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_next = TX_START;
                end
            end
            TX_START: begin
                if (w_baud_done) begin
                    w_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                w_bit_next = w_baud_done ? (r_bit_idx + BIT_W'(1)) : r_bit_idx;
                if (w_baud_done && (r_bit_idx == c_BIT_LAST)) begin
                    w_state_next = TX_STOP;
                end
            end
            TX_STOP: begin
                if (w_baud_done) begin
                    w_state_next = TX_IDLE;
                end
            end
            default: w_state_next = TX_IDLE;
        endcase
    end

    // Line level for the coming cycle, registered so TXD never glitches;
    // busy follows the current state.
    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            TX_START: w_txd_next = 1'b0;
            TX_DATA:  w_txd_next = r_data[w_bit_next];
            default:  w_txd_next = 1'b1;
        endcase
        TX_BUSY = (r_state != TX_IDLE);
    end

    assign TXD      = r_txd;
    assign FIFO_CNT = w_count;
    assign OVF      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_lc3_console_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lc3_console_tx
//  Description : Self-checking bench for lc3_console_tx: queue-based line
//                model compared every cycle, an independent UART decoder,
//                directed scenarios and a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_console_tx;

    localparam int C  = 4;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;
    localparam int FRAME = 10 * C;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   DDR = 16'h0000;
    logic          WR_DDR = 1'b0;
    logic          TXD;
    logic          TX_BUSY;
    logic [CW-1:0] FIFO_CNT;
    logic          OVF;

    lc3_console_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .DDR      (DDR),
        .WR_DDR   (WR_DDR),
        .TXD      (TXD),
        .TX_BUSY  (TX_BUSY),
        .FIFO_CNT (FIFO_CNT),
        .OVF      (OVF)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // ------------------------------------------------------------------
    // Behavioural model: a character queue plus the position inside the
    // frame currently on the wire.
    // ------------------------------------------------------------------
    byte unsigned mq[$];
    bit           m_busy  = 0;
    int           m_pos   = 0;
    byte unsigned m_cur   = 0;
    bit           m_ovf   = 0;
    bit           m_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_busy  = 0;
            m_pos   = 0;
            m_ovf   = 0;
            m_valid = 1;
        end else begin
            if (m_busy) begin
                m_pos++;
                if (m_pos == FRAME) m_busy = 0;
            end else if (mq.size() != 0) begin
                m_cur  = mq.pop_front();
                m_busy = 1;
                m_pos  = 0;
            end
            if (WR_DDR) begin
                if (mq.size() < D) mq.push_back(DDR[7:0]);
                else               m_ovf = 1;
            end
        end
    end

    function automatic logic exp_txd();
        int k;
        if (!m_busy) return 1'b1;
        k = m_pos / C;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
        return 1'b1;
    endfunction

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (m_valid) begin
            check("txd",      {31'd0, TXD},      {31'd0, exp_txd()});
            check("busy",     {31'd0, TX_BUSY},  {31'd0, m_busy});
            check("fifo_cnt", 32'(FIFO_CNT),     32'(mq.size()));
            check("ovf",      {31'd0, OVF},      {31'd0, m_ovf});
        end
    end

    // ------------------------------------------------------------------
    // Independent line decoder: mid-bit sampling of each frame
    // ------------------------------------------------------------------
    byte unsigned mon_bytes[$];
    int           mon_starts[$];
    bit           mon_active = 0;
    int           mon_start  = 0;
    logic [7:0]   mon_byte   = 8'h00;
    logic         prev_txd   = 1'b1;
    int           busy_cycles = 0;
    int           mon_off;

    always @(negedge clk) begin
        if (TX_BUSY === 1'b1) busy_cycles++;
        if (reset) begin
            mon_active = 0;
        end else if (!mon_active) begin
            if (prev_txd === 1'b1 && TXD === 1'b0) begin
                mon_active = 1;
                mon_start  = cyc;
                mon_byte   = 8'h00;
            end
        end else begin
            mon_off = cyc - mon_start;
            for (int k = 1; k <= 8; k++) begin
                if (mon_off == C * k + C / 2) mon_byte[k-1] = TXD;
            end
            if (mon_off == 9 * C + C / 2) begin
                check("stop_bit", {31'd0, TXD}, 32'd1);
                mon_bytes.push_back(mon_byte);
                mon_starts.push_back(mon_start);
                mon_active = 0;
            end
        end
        prev_txd = TXD;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_bytes.delete();
        mon_starts.delete();
        busy_cycles = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((TX_BUSY !== 1'b0 || FIFO_CNT !== '0) && n < 2000) begin
            tick();
            n++;
        end
        check("drain_timeout", {31'd0, (n < 2000)}, 32'd1);
        repeat (3) tick();
    endtask

    task automatic check_bytes(input string name, input byte unsigned exp[$]);
        check({name, "_nbytes"}, 32'(mon_bytes.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < mon_bytes.size(); i++) begin
            check({name, "_byte"}, 32'(mon_bytes[i]), 32'(exp[i]));
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #5000000;
        $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int t0;
        int burst;
        byte unsigned e[$];

        repeat (3) tick();
        reset = 1'b0;
        check("rst_txd",  {31'd0, TXD},     32'd1);
        check("rst_busy", {31'd0, TX_BUSY}, 32'd0);
        check("rst_cnt",  32'(FIFO_CNT),    32'd0);
        check("rst_ovf",  {31'd0, OVF},     32'd0);
        tick();

        // Single character 'A'
        clear_mon();
        t0 = cyc;
        DDR = 16'h0041; WR_DDR = 1'b1;
        tick();
        WR_DDR = 1'b0;
        check("t1_cnt_after_push", 32'(FIFO_CNT), 32'd1);
        check("t1_txd_idle",       {31'd0, TXD},  32'd1);
        tick();
        check("t1_txd_start", {31'd0, TXD},     32'd0);
        check("t1_busy",      {31'd0, TX_BUSY}, 32'd1);
        check("t1_cnt_popped", 32'(FIFO_CNT),   32'd0);
        drain();
        e = {8'h41};
        check_bytes("t1", e);
        if (mon_starts.size() > 0) check("t1_start_latency", 32'(mon_starts[0] - t0), 32'd2);
        check("t1_busy_cycles", 32'(busy_cycles), 32'd40);

        // Back-to-back 'H','i'
        clear_mon();
        DDR = 16'h0048; WR_DDR = 1'b1;
        tick();
        check("t2_cnt_1", 32'(FIFO_CNT), 32'd1);
        DDR = 16'h0069;
        tick();
        WR_DDR = 1'b0;
        check("t2_cnt_2", 32'(FIFO_CNT), 32'd1);
        drain();
        e = {8'h48, 8'h69};
        check_bytes("t2", e);
        if (mon_starts.size() > 1) check("t2_spacing", 32'(mon_starts[1] - mon_starts[0]), 32'd41);
        check("t2_busy_cycles", 32'(busy_cycles), 32'd80);

        // Overflow: six consecutive pushes, the last one is dropped
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            DDR = 16'h0030 + 16'(i); WR_DDR = 1'b1;
            tick();
        end
        WR_DDR = 1'b0;
        check("t3_ovf", {31'd0, OVF},  32'd1);
        check("t3_cnt", 32'(FIFO_CNT), 32'd4);
        drain();
        e = {8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
        check_bytes("t3", e);
        check("t3_ovf_sticky", {31'd0, OVF}, 32'd1);
        pulse_reset();
        check("t3_ovf_cleared", {31'd0, OVF}, 32'd0);

        // Full FIFO with a push on the idle pop edge
        clear_mon();
        t0 = cyc;
        for (int i = 0; i < 5; i++) begin
            DDR = 16'h0060 + 16'(i); WR_DDR = 1'b1;
            tick();
        end
        WR_DDR = 1'b0;
        check("t4_full", 32'(FIFO_CNT), 32'd4);
        while (cyc < t0 + 42) tick();
        check("t4_idle_gap", {31'd0, TX_BUSY}, 32'd0);
        check("t4_cnt_pre", 32'(FIFO_CNT), 32'd4);
        DDR = 16'h0065; WR_DDR = 1'b1;
        tick();
        WR_DDR = 1'b0;
        check("t4_cnt_post", 32'(FIFO_CNT), 32'd4);
        check("t4_ovf",      {31'd0, OVF},  32'd0);
        drain();
        e = {8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        check_bytes("t4", e);

        // Reset during data bit 3 of 0x55 with two characters queued
        clear_mon();
        t0 = cyc;
        DDR = 16'h0055; WR_DDR = 1'b1; tick();
        DDR = 16'h00A1; tick();
        DDR = 16'h00A2; tick();
        WR_DDR = 1'b0;
        while (cyc < t0 + 19) tick();
        check("t5_cnt_queued", 32'(FIFO_CNT), 32'd2);
        check("t5_bit3",       {31'd0, TXD},  32'd0);
        reset = 1'b1;
        tick();
        check("t5_txd",  {31'd0, TXD},     32'd1);
        check("t5_cnt",  32'(FIFO_CNT),    32'd0);
        check("t5_ovf",  {31'd0, OVF},     32'd0);
        check("t5_busy", {31'd0, TX_BUSY}, 32'd0);
        reset = 1'b0;
        clear_mon();
        repeat (100) tick();
        check("t5_no_frames", 32'(mon_bytes.size()), 32'd0);
        check("t5_no_busy",   32'(busy_cycles),       32'd0);

        // Upper byte ignored, pointers wrap over nine characters
        clear_mon();
        for (int n = 0; n < 9; n++) begin
            DDR = 16'hFF00 + 16'(n); WR_DDR = 1'b1;
            tick();
            WR_DDR = 1'b0;
            repeat (29) tick();
        end
        drain();
        e = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        check_bytes("t6", e);
        check("t6_ovf", {31'd0, OVF}, 32'd0);

        // Randomized traffic with bursts and occasional resets
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            if (burst == 0 && $urandom_range(0, 149) == 0) burst = $urandom_range(3, 8);
            DDR = 16'($urandom);
            if (burst > 0) begin
                WR_DDR = 1'b1;
                burst--;
            end else begin
                WR_DDR = ($urandom_range(0, 11) == 0);
            end
            reset = ($urandom_range(0, 699) == 0);
            tick();
        end
        WR_DDR = 1'b0;
        reset  = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
